fetch_queue_unit: RTL and testbench
===================================

Name: fetch_queue_unit

Overview:
- Parametrised successor to the single-cycle instruction fetch stage.
- Owns the PC and issues requests to a variable-latency instruction memory over a valid/ready handshake.
- Buffers returned instructions with their PC+INC in a DEPTH-entry prefetch queue feeding decode through valid/ready.
- Handles redirects (rti, siic, jalr, branch/jump), halt, and flushing of in-flight fetches so decode never sees wrong-path instructions.

Parameters:
- W, 16, address/instruction width.
- DEPTH, 4, prefetch queue entries (power of two, >=2).
- RESET_PC, 16'h0000, PC value after reset.
- EXC_VEC, 16'h0002, siic target.
- INC, 2, PC increment per fetch.
- NOP_INSTR, 16'h0800, value on dec_instr when queue empty.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- halt  in  1  stop issuing new fetches; queue still drains.
- rti  in  1  redirect to epc.
- epc  in  W  rti target.
- siic  in  1  redirect to EXC_VEC.
- jalr  in  1  redirect to jalr_addr.
- jalr_addr  in  W  jalr target.
- branch  in  1  redirect to branch_addr.
- jump  in  1  redirect to branch_addr.
- branch_addr  in  W  branch/jump target.
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  W  fetch address (current PC).
- imem_req_ready  in  1  memory accepts request.
- imem_rsp_valid  in  1  response data valid (one per accepted request, in order).
- imem_rsp_data  in  W  instruction word.
- dec_valid  out  1  head entry valid.
- dec_instr  out  W  head instruction, NOP_INSTR when !dec_valid.
- dec_pc_add2  out  W  head PC+INC.
- dec_ready  in  1  decode consumes head.

Behaviour:
- Reset (rst=0, async): PC=RESET_PC; queue empty (count=0, pointers 0); outstanding=0; stale=0. Outputs: imem_req_valid=0, dec_valid=0, dec_instr=NOP_INSTR, dec_pc_add2=0.
- Redirect priority, highest first: rti > siic > jalr > (branch|jump). redir = OR of all four.
- On a redirect cycle:
  - PC <= selected target.
  - Queue flushed (count=0).
  - If a request is outstanding and its response has not arrived this cycle, stale <= 1.
  - imem_req_valid forced 0.
  - A dec_ready pop in the same cycle is ignored (flush wins).
- Issue condition: imem_req_valid = !halt & !redir & !outstanding & (count < DEPTH); imem_req_addr = PC.
- At most one request outstanding.
- On accept (valid & ready): PC <= PC+INC modulo 2^W (wraps silently); outstanding <= 1; req_pc_add2 <= PC+INC.
- Response handling (imem_rsp_valid):
  - Always clears outstanding.
  - stale=1: data discarded, stale cleared.
  - Redirect in the same cycle: data discarded.
  - Otherwise {data, req_pc_add2} pushed at tail.
  - A response may arrive in the same cycle a new request is accepted only if outstanding was already clear; a response with outstanding=0 is a protocol error (ignored, assertion flags it).
- Pop: dec_valid = (count != 0); pop when dec_valid & dec_ready & !redir.
- Occupancy and ordering:
  - Push and pop in the same cycle leaves count unchanged.
  - Space is reserved at issue, so a push never occurs when full.
  - Pointers wrap modulo DEPTH.
  - Instructions leave in fetch order.
- halt: blocks new issue only; an outstanding response is still queued; decode still pops. Redirect during halt updates PC, and the redirect takes effect on halt deassertion.
- Latency: with a memory that holds imem_req_ready=1 and responds one cycle after accept, an instruction is on dec_* two cycles after its PC is presented. Steady-state throughput is one fetch per 2 cycles (single outstanding).
- Reset asserted mid-operation: immediate return to reset state; any later stray response is ignored via the outstanding=0 rule.

Decomposition:
- Shared package fetch_pkg: RESET_PC, EXC_VEC, NOP_INSTR, INC defaults, and a redirect-select encoding (RTI, SIIC, JALR, BR).
- Sub-module fetch_fifo: parametrised W*2-wide, DEPTH-deep synchronous FIFO with flush, push, pop, count, and full/empty. The PC/redirect/request control stays in the top module.

Test Plan:
- Reset, then memory ready with 1-cycle response returning PC-derived data -> requests to 0x0000, 0x0002, 0x0004; dec_instr in order with dec_pc_add2 = 0x0002, 0x0004, 0x0006; dec_instr = 0x0800 before the first valid.
- dec_ready=0 for 10 cycles -> exactly 4 entries queued, imem_req_valid=0 while count=4; releasing dec_ready drains in order, then issue resumes.
- Request to 0x0006 outstanding, branch=1 with branch_addr=0x0040, response arrives 2 cycles later -> response dropped, queue empty, next request to 0x0040, first dec_pc_add2=0x0042.
- rti=1, siic=1, jalr=1, and branch=1 in the same cycle, epc=0x0100 -> next request address 0x0100; siic alone -> 0x0002.
- PC=0xFFFE fetch accepted -> PC wraps to 0x0000; dec_pc_add2=0x0000.
- halt=1 with one outstanding request -> that instruction is queued, no further requests; rst pulsed low mid-fetch -> all outputs return to reset values asynchronously, and a late response is not queued.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants and redirect-select encoding for the fetch queue unit.
package fetch_pkg;

    localparam int unsigned FQ_W            = 16;
    localparam int unsigned FQ_DEPTH        = 4;
    localparam int unsigned FQ_INC          = 2;
    localparam logic [15:0] FQ_RESET_PC     = 16'h0000;
    localparam logic [15:0] FQ_EXC_VEC      = 16'h0002;
    localparam logic [15:0] FQ_NOP_INSTR    = 16'h0800;

    typedef enum logic [1:0] {
        SEL_RTI,
        SEL_SIIC,
        SEL_JALR,
        SEL_BR
    } redir_sel_e;

    // Priority: rti > siic > jalr > branch/jump.
    function automatic redir_sel_e redir_select(
        input logic rti,
        input logic siic,
        input logic jalr
    );
        if (rti) begin
            return SEL_RTI;
        end else if (siic) begin
            return SEL_SIIC;
        end else if (jalr) begin
            return SEL_JALR;
        end
        return SEL_BR;
    endfunction

endpackage

// File: rtl/fetch_queue_unit_fifo.sv
// Prefetch ring buffer with synchronous flush; pushes while
// full and pops while empty are dropped.
module fetch_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic [DW-1:0]          push_data,
    input  logic                   pop,
    output logic [DW-1:0]          pop_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full && !flush;
    assign do_pop   = pop && !empty && !flush;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/fetch_queue_unit.sv
// Fetch stage: owns the PC, issues single-outstanding imem requests
// and queues returned instructions for decode.
module fetch_queue_unit
    import fetch_pkg::*;
#(
    parameter int             W         = FQ_W,
    parameter int             DEPTH     = FQ_DEPTH,
    parameter logic [W-1:0]   RESET_PC  = W'(FQ_RESET_PC),
    parameter logic [W-1:0]   EXC_VEC   = W'(FQ_EXC_VEC),
    parameter int             INC       = FQ_INC,
    parameter logic [W-1:0]   NOP_INSTR = W'(FQ_NOP_INSTR)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         halt,
    input  logic         rti,
    input  logic [W-1:0] epc,
    input  logic         siic,
    input  logic         jalr,
    input  logic [W-1:0] jalr_addr,
    input  logic         branch,
    input  logic         jump,
    input  logic [W-1:0] branch_addr,
    output logic         imem_req_valid,
    output logic [W-1:0] imem_req_addr,
    input  logic         imem_req_ready,
    input  logic         imem_rsp_valid,
    input  logic [W-1:0] imem_rsp_data,
    output logic         dec_valid,
    output logic [W-1:0] dec_instr,
    output logic [W-1:0] dec_pc_add2,
    input  logic         dec_ready
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [W-1:0]   pc;
    logic [W-1:0]   pc_inc;
    logic [W-1:0]   req_pc_add2;
    logic [W-1:0]   target;
    logic           outstanding;
    logic           stale;
    logic           redir;
    logic           acc;
    logic           rsp_ok;
    logic           q_push;
    logic           q_pop;
    logic           q_full;
    logic           q_empty;
    logic [CW-1:0]  q_count;
    logic [2*W-1:0] q_head;
    redir_sel_e     sel;

    assign redir  = rti || siic || jalr || branch || jump;
    assign sel    = redir_select(rti, siic, jalr);
    assign pc_inc = pc + W'(INC);

    always_comb begin
        target = branch_addr;
        unique case (sel)
            SEL_RTI:  target = epc;
            SEL_SIIC: target = EXC_VEC;
            SEL_JALR: target = jalr_addr;
            SEL_BR:   target = branch_addr;
        endcase
    end

    // Issue only with a free slot reserved, so responses never overflow.
    assign imem_req_valid = rst && !halt && !redir && !outstanding
                         && (q_count < CW'(DEPTH));
    assign imem_req_addr  = pc;
    assign acc            = imem_req_valid && imem_req_ready;
    assign rsp_ok         = imem_rsp_valid && outstanding;

    assign q_push = rsp_ok && !stale && !redir;
    assign q_pop  = dec_valid && dec_ready && !redir;

    assign dec_valid   = !q_empty;
    assign dec_instr   = dec_valid ? q_head[2*W-1:W] : NOP_INSTR;
    assign dec_pc_add2 = dec_valid ? q_head[W-1:0] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc          <= RESET_PC;
            req_pc_add2 <= '0;
            outstanding <= 1'b0;
            stale       <= 1'b0;
        end else begin
            if (redir) begin
                pc <= target;
            end else if (acc) begin
                pc <= pc_inc;
            end
            if (acc) begin
                outstanding <= 1'b1;
                req_pc_add2 <= pc_inc;
            end else if (imem_rsp_valid) begin
                outstanding <= 1'b0;
            end
            // A redirect orphans the in-flight fetch; drop its data later.
            if (redir && outstanding && !imem_rsp_valid) begin
                stale <= 1'b1;
            end else if (rsp_ok) begin
                stale <= 1'b0;
            end
        end
    end

    fetch_fifo #(
        .DW    (2 * W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redir),
        .push      (q_push),
        .push_data ({imem_rsp_data, req_pc_add2}),
        .pop       (q_pop),
        .pop_data  (q_head),
        .count     (q_count),
        .full      (q_full),
        .empty     (q_empty)
    );

    a_no_stray_rsp: assert property (
        @(posedge clk) disable iff (!rst) imem_rsp_valid |-> outstanding
    ) else $error("imem response with no request outstanding");

    a_no_push_full: assert property (
        @(posedge clk) disable iff (!rst) q_push |-> !q_full
    ) else $error("prefetch queue push while full");

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit with a small latency-configurable
// instruction memory returning addr + 0x1000.
module tb_fetch_queue_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        halt;
    logic        rti;
    logic [15:0] epc;
    logic        siic;
    logic        jalr;
    logic [15:0] jalr_addr;
    logic        branch;
    logic        jump;
    logic [15:0] branch_addr;
    logic        imem_req_valid;
    logic [15:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [15:0] imem_rsp_data;
    logic        dec_valid;
    logic [15:0] dec_instr;
    logic [15:0] dec_pc_add2;
    logic        dec_ready;

    int          checks = 0;
    int          errors = 0;

    int          mem_lat = 1;
    int          mem_wait = 0;
    logic        mem_busy = 1'b0;
    logic [15:0] mem_addr = '0;
    logic        last_req_valid;
    logic [15:0] acc_log[$];
    logic [31:0] pop_log[$];

    always #5 clk = ~clk;

    fetch_queue_unit dut (
        .clk            (clk),
        .rst            (rst),
        .halt           (halt),
        .rti            (rti),
        .epc            (epc),
        .siic           (siic),
        .jalr           (jalr),
        .jalr_addr      (jalr_addr),
        .branch         (branch),
        .jump           (jump),
        .branch_addr    (branch_addr),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .dec_valid      (dec_valid),
        .dec_instr      (dec_instr),
        .dec_pc_add2    (dec_pc_add2),
        .dec_ready      (dec_ready)
    );

    // One clock: called at a negedge with inputs set, returns at the next.
    task automatic step();
        logic        acc;
        logic [15:0] addr;
        if (mem_busy && mem_wait == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_addr + 16'h1000;
        end else begin
            imem_rsp_valid = 1'b0;
        end
        #1;
        last_req_valid = imem_req_valid;
        acc  = imem_req_valid && imem_req_ready;
        addr = imem_req_addr;
        if (acc) acc_log.push_back(addr);
        if (dec_valid && dec_ready && !(rti || siic || jalr || branch || jump))
            pop_log.push_back({dec_instr, dec_pc_add2});
        @(posedge clk);
        if (imem_rsp_valid) mem_busy = 1'b0;
        if (acc) begin
            mem_busy = 1'b1;
            mem_wait = mem_lat - 1;
            mem_addr = addr;
        end else if (mem_busy && mem_wait > 0) begin
            mem_wait = mem_wait - 1;
        end
        @(negedge clk);
        imem_rsp_valid = 1'b0;
    endtask

    task automatic quiesce();
        {rti, siic, jalr, branch, jump} = '0;
        halt = 1'b1;
        dec_ready = 1'b1;
        repeat (6) step();
        halt = 1'b0;
    endtask

    task automatic clear_logs();
        acc_log.delete();
        pop_log.delete();
    endtask

    task automatic test_reset();
        checks++;
        if (imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_req_valid got %b want 0", imem_req_valid);
        end
        checks++;
        if (dec_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_dec_valid got %b want 0", dec_valid);
        end
        checks++;
        if (dec_instr !== 16'h0800) begin
            errors++;
            $display("FAIL reset_dec_instr got %h want 0800", dec_instr);
        end
        checks++;
        if (dec_pc_add2 !== 16'h0000) begin
            errors++;
            $display("FAIL reset_pc_add2 got %h want 0000", dec_pc_add2);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 16'h0000) begin
            errors++;
            $display("FAIL first_req got %b/%h want 1/0000",
                     imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_basic();
        clear_logs();
        dec_ready = 1'b1;
        halt = 1'b0;
        step();
        checks++;
        if (dec_valid !== 1'b0 || dec_instr !== 16'h0800) begin
            errors++;
            $display("FAIL basic_nop got %b/%h want 0/0800", dec_valid, dec_instr);
        end
        step();
        checks++;
        if (dec_valid !== 1'b1 || dec_instr !== 16'h1000) begin
            errors++;
            $display("FAIL basic_latency got %b/%h want 1/1000", dec_valid, dec_instr);
        end
        repeat (4) step();
        halt = 1'b1;
        repeat (2) step();
        halt = 1'b0;
        checks++;
        if (acc_log.size() != 3 || acc_log[0] !== 16'h0000
            || acc_log[1] !== 16'h0002 || acc_log[2] !== 16'h0004) begin
            errors++;
            $display("FAIL basic_req_addrs got %0d entries %p want 0000,0002,0004",
                     acc_log.size(), acc_log);
        end
        checks++;
        if (pop_log.size() != 3 || pop_log[0] !== 32'h1000_0002
            || pop_log[1] !== 32'h1002_0004 || pop_log[2] !== 32'h1004_0006) begin
            errors++;
            $display("FAIL basic_pops got %p want 10000002,10020004,10040006", pop_log);
        end
    endtask

    task automatic test_backpressure();
        clear_logs();
        dec_ready = 1'b0;
        halt = 1'b0;
        repeat (10) step();
        checks++;
        if (acc_log.size() != 4 || acc_log[0] !== 16'h0006
            || acc_log[3] !== 16'h000C) begin
            errors++;
            $display("FAIL bp_fill got %p want 0006,0008,000a,000c", acc_log);
        end
        checks++;
        if (imem_req_valid !== 1'b0 || last_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_full_issue got %b/%b want 0/0",
                     imem_req_valid, last_req_valid);
        end
        checks++;
        if (dec_valid !== 1'b1 || dec_instr !== 16'h1006 || pop_log.size() != 0) begin
            errors++;
            $display("FAIL bp_head got %b/%h pops %0d want 1/1006 pops 0",
                     dec_valid, dec_instr, pop_log.size());
        end
        dec_ready = 1'b1;
        repeat (4) step();
        quiesce();
        checks++;
        if (pop_log.size() != 6 || pop_log[0] !== 32'h1006_0008
            || pop_log[1] !== 32'h1008_000A || pop_log[2] !== 32'h100A_000C
            || pop_log[3] !== 32'h100C_000E || pop_log[4] !== 32'h100E_0010
            || pop_log[5] !== 32'h1010_0012) begin
            errors++;
            $display("FAIL bp_drain got %p want 10060008..10100012", pop_log);
        end
        checks++;
        if (acc_log.size() != 6 || acc_log[4] !== 16'h000E
            || acc_log[5] !== 16'h0010) begin
            errors++;
            $display("FAIL bp_resume got %p want ...,000e,0010", acc_log);
        end
    endtask

    task automatic test_flush();
        clear_logs();
        halt = 1'b1;
        branch = 1'b1;
        branch_addr = 16'h0006;
        step();
        branch = 1'b0;
        halt = 1'b0;
        dec_ready = 1'b1;
        mem_lat = 3;
        step();
        branch = 1'b1;
        branch_addr = 16'h0040;
        step();
        branch = 1'b0;
        checks++;
        if (last_req_valid !== 1'b0 || dec_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_redir_cycle got req %b dec %b want 0/0",
                     last_req_valid, dec_valid);
        end
        repeat (2) step();
        checks++;
        if (dec_valid !== 1'b0 || acc_log.size() != 1 || acc_log[0] !== 16'h0006) begin
            errors++;
            $display("FAIL flush_stale_drop got dec %b reqs %p want 0 / 0006",
                     dec_valid, acc_log);
        end
        mem_lat = 1;
        repeat (3) step();
        checks++;
        if (acc_log.size() < 2 || acc_log[1] !== 16'h0040) begin
            errors++;
            $display("FAIL flush_target got %p want 0006,0040", acc_log);
        end
        checks++;
        if (pop_log.size() != 1 || pop_log[0] !== 32'h1040_0042) begin
            errors++;
            $display("FAIL flush_first_pop got %p want 10400042", pop_log);
        end
        quiesce();
    endtask

    task automatic test_priority();
        clear_logs();
        dec_ready = 1'b0;
        halt = 1'b0;
        repeat (2) step();
        {rti, siic, jalr, branch} = 4'b1111;
        epc = 16'h0100;
        jalr_addr = 16'h0200;
        branch_addr = 16'h0300;
        dec_ready = 1'b1;
        step();
        {rti, siic, jalr, branch} = 4'b0000;
        checks++;
        if (last_req_valid !== 1'b0 || pop_log.size() != 0 || dec_valid !== 1'b0) begin
            errors++;
            $display("FAIL prio_flush_wins got req %b pops %0d dec %b want 0/0/0",
                     last_req_valid, pop_log.size(), dec_valid);
        end
        step();
        checks++;
        if (acc_log.size() != 2 || acc_log[1] !== 16'h0100) begin
            errors++;
            $display("FAIL prio_rti got %p want 0044,0100", acc_log);
        end
        quiesce();

        clear_logs();
        halt = 1'b1;
        siic = 1'b1;
        step();
        siic = 1'b0;
        halt = 1'b0;
        step();
        checks++;
        if (acc_log.size() != 1 || acc_log[0] !== 16'h0002) begin
            errors++;
            $display("FAIL prio_siic got %p want 0002", acc_log);
        end
        quiesce();

        clear_logs();
        halt = 1'b1;
        {jalr, branch, jump} = 3'b111;
        step();
        {jalr, branch, jump} = 3'b000;
        halt = 1'b0;
        step();
        checks++;
        if (acc_log.size() != 1 || acc_log[0] !== 16'h0200) begin
            errors++;
            $display("FAIL prio_jalr got %p want 0200", acc_log);
        end
        quiesce();
    endtask

    task automatic test_wrap();
        clear_logs();
        halt = 1'b1;
        jump = 1'b1;
        branch_addr = 16'hFFFE;
        step();
        jump = 1'b0;
        halt = 1'b0;
        dec_ready = 1'b1;
        repeat (4) step();
        checks++;
        if (acc_log.size() != 2 || acc_log[0] !== 16'hFFFE || acc_log[1] !== 16'h0000) begin
            errors++;
            $display("FAIL wrap_pc got %p want fffe,0000", acc_log);
        end
        checks++;
        if (pop_log.size() != 1 || pop_log[0] !== 32'h0FFE_0000) begin
            errors++;
            $display("FAIL wrap_pc_add2 got %p want 0ffe0000", pop_log);
        end
        quiesce();
    endtask

    task automatic test_halt_reset();
        clear_logs();
        dec_ready = 1'b0;
        halt = 1'b0;
        step();
        halt = 1'b1;
        repeat (3) step();
        checks++;
        if (acc_log.size() != 1 || acc_log[0] !== 16'h0002 || imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL halt_issue got %p req %b want 0002 / 0",
                     acc_log, imem_req_valid);
        end
        checks++;
        if (dec_valid !== 1'b1 || dec_instr !== 16'h1002 || dec_pc_add2 !== 16'h0004) begin
            errors++;
            $display("FAIL halt_queued got %b/%h/%h want 1/1002/0004",
                     dec_valid, dec_instr, dec_pc_add2);
        end
        halt = 1'b0;
        step();
        rst = 1'b0;
        #1;
        checks++;
        if (imem_req_valid !== 1'b0 || dec_valid !== 1'b0
            || dec_instr !== 16'h0800 || dec_pc_add2 !== 16'h0000) begin
            errors++;
            $display("FAIL async_reset got %b/%b/%h/%h want 0/0/0800/0000",
                     imem_req_valid, dec_valid, dec_instr, dec_pc_add2);
        end
        step();
        rst = 1'b1;
        halt = 1'b1;
        step();
        checks++;
        if (dec_valid !== 1'b0 || dec_instr !== 16'h0800) begin
            errors++;
            $display("FAIL late_rsp got %b/%h want 0/0800", dec_valid, dec_instr);
        end
        clear_logs();
        halt = 1'b0;
        step();
        checks++;
        if (acc_log.size() != 1 || acc_log[0] !== 16'h0000) begin
            errors++;
            $display("FAIL post_reset_pc got %p want 0000", acc_log);
        end
        quiesce();
    endtask

    initial begin
        rst = 1'b0;
        {halt, rti, siic, jalr, branch, jump} = '0;
        epc = '0;
        jalr_addr = '0;
        branch_addr = '0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = '0;
        dec_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_backpressure();
        test_flush();
        test_priority();
        test_wrap();
        test_halt_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
